uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a byte handshake, latches the parity of the byte, and drives the serializer enable. It also drives the line-select mux that builds start / data / parity / stop bits, and produces the registered TX line and the busy flag. It sits between the host-side Data_Valid interface and the shift-register serializer, one bit per CLK.

Parameters:
WIDTH, 8, data width for parity computation; must be 8 to match the serializer's 3-bit ser_done count

Ports:
CLK  in  1  transmit bit clock; all state on rising edge
RST  in  1  synchronous, active-high reset
P_DATA  in  WIDTH  byte offered by host, used only for the parity latch
Data_Valid  in  1  host strobe; accepted only when busy=0
PAR_EN  in  1  1 = insert parity bit; sampled on accept
PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept
ser_done  in  1  serializer flag, high while its bit counter = 7
ser_out  in  1  serializer current bit (LSB of its shift register)
ser_en  out  1  serializer shift/count enable
mux_sel  out  2  line source: 0 start(0), 1 idle/stop(1), 2 ser_out, 3 parity
busy  out  1  frame in progress; host and serializer must not load
TX_OUT  out  1  registered serial line

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset values: state=IDLE, ser_en=0, mux_sel=1, busy=0, TX_OUT=1, par_bit=0, par_en_q=0.
- States: IDLE, START, DATA, PARITY, STOP (one-hot or binary; encoding is free).
- IDLE: busy=0, mux_sel=1.
  - If Data_Valid=1, then on that edge: par_bit <= ^P_DATA ^ PAR_TYP, par_en_q <= PAR_EN, state -> START.
  - The serializer loads the same edge from its own Data_Valid && !busy term.
- START: mux_sel=0, busy=1; always -> DATA next edge.
- DATA: ser_en=1, mux_sel=2, busy=1.
  - Stay while ser_done=0.
  - When ser_done=1 (8th data cycle), go to PARITY if par_en_q=1, else STOP.
- PARITY: mux_sel=3, busy=1; -> STOP.
- STOP: mux_sel=1, busy=1; -> IDLE. Data_Valid is ignored in STOP.
- ser_en, mux_sel and busy are decoded combinationally from the state register only, with no input-to-output paths.
  - ser_en is 0 in every non-DATA state, so the serializer counter clears between frames.
- TX_OUT <= mux(mux_sel) each edge. TX_OUT therefore lags the state by exactly 1 cycle.
- Frame length: 11 cycles of busy with parity, 10 without. The minimum inter-frame gap is 1 IDLE cycle.
- Data_Valid held high continuously produces back-to-back frames separated by 1 idle (TX_OUT=1) cycle.
- PAR_EN, PAR_TYP and P_DATA changing mid-frame have no effect on the current frame.
- ser_done=1 outside DATA is ignored.
- RST mid-frame: next edge forces IDLE, busy=0 and TX_OUT=1, with no partial stop bit.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts 2 cycles via a 1-bit stop counter, which is cleared on entry. Frame is 12 cycles with parity, 11 without.
- Undefined: the counter is absent and STOP is a single cycle.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - mux_sel constants (SEL_START=0, SEL_IDLE=1, SEL_DATA=2, SEL_PAR=3);
  - the frame-length constants.
- One natural sub-module: uart_tx_mux, a 4:1 line-select mux with the TX_OUT register, reset to 1.
- The FSM and the parity latch stay in uart_tx_ctrl.

Test Plan:
1. Reset held 3 cycles, then released with Data_Valid=0 -> TX_OUT=1, busy=0, ser_en=0, mux_sel=1 steady for 20 cycles.
2. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulsed at cycle 0 (with the serializer model attached):
   - busy high cycles 1-11;
   - ser_en high cycles 2-9;
   - TX_OUT: cycle 2 = 0, cycles 3-10 = 1,0,1,0,0,1,0,1, cycle 11 = 0 (parity), cycle 12 = 1.
3. Same byte with PAR_TYP=1 -> parity bit 1. With PAR_EN=0 -> no parity; stop bit at cycle 11, busy cycles 1-10.
4. Data_Valid held high across two frames (8'h00, then 8'hFF) -> exactly 1 idle cycle between frames. Data_Valid is not accepted while busy=1, and the second frame's even parity is 0.
5. RST asserted in DATA at cycle 5 -> next edge busy=0, ser_en=0, TX_OUT=1. A new Data_Valid afterwards yields a clean full frame.
6. With UART_TX_TWO_STOP_EN defined, the same stimulus as scenario 2 -> TX_OUT=1 for cycles 12-13, busy high cycles 1-12, next accept no earlier than cycle 13.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared encodings for the UART transmit frame sequencer: FSM states, line-select codes, frame lengths.
// UART_TX_TWO_STOP_EN selects a two-cycle stop bit.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_IDLE  = 2'd1;
    localparam logic [1:0] SEL_DATA  = 2'd2;
    localparam logic [1:0] SEL_PAR   = 2'd3;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam int FRAME_LEN_PAR   = 1 + DATA_BITS + 1 + STOP_BITS;
    localparam int FRAME_LEN_NOPAR = 1 + DATA_BITS + STOP_BITS;

    // Parity bit for a byte: even parity when odd_sel=0, odd parity when odd_sel=1.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_mux.sv
// 4:1 TX line-select mux feeding the registered serial line; the line idles high.
import uart_tx_ctrl_pkg::*;

module uart_tx_mux (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] mux_sel,
    input  logic       ser_out,
    input  logic       par_bit,
    output logic       TX_OUT
);

    logic line_s;

    // Line source selection.
    always_comb begin
        line_s = 1'b1;
        case (mux_sel)
            SEL_START: line_s = 1'b0;
            SEL_IDLE:  line_s = 1'b1;
            SEL_DATA:  line_s = ser_out;
            SEL_PAR:   line_s = par_bit;
            default:   line_s = 1'b1;
        endcase
    end

    // Output register; reset drives the idle (mark) level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_OUT <= 1'b1;
        end else begin
            TX_OUT <= line_s;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, latches its parity and steps start/data/parity/stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
import uart_tx_ctrl_pkg::*;

module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_done,
    input  logic             ser_out,
    output logic             ser_en,
    output logic [1:0]       mux_sel,
    output logic             busy,
    output logic             TX_OUT
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic       par_bit_r;
    logic       par_en_r;
    logic       ser_en_s;
    logic [1:0] mux_sel_s;
    logic       busy_s;
    logic       stop_last_s;

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt_r;

    // Stop-bit counter: held at zero outside STOP so it restarts on every entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_cnt_r <= 1'b0;
        end else if (state_r != ST_STOP) begin
            stop_cnt_r <= 1'b0;
        end else begin
            stop_cnt_r <= ~stop_cnt_r;
        end
    end

    assign stop_last_s = stop_cnt_r;
`else
    assign stop_last_s = 1'b1;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Parity latch: frame settings are frozen at accept time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) && Data_Valid) begin
            par_bit_r <= parity_of(P_DATA, PAR_TYP);
            par_en_r  <= PAR_EN;
        end else begin
            par_bit_r <= par_bit_r;
            par_en_r  <= par_en_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: state_nxt_s = ST_DATA;
            ST_DATA: begin
                if (!ser_done) begin
                    state_nxt_s = ST_DATA;
                end else if (par_en_r) begin
                    state_nxt_s = ST_PARITY;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_PARITY: state_nxt_s = ST_STOP;
            ST_STOP: begin
                if (stop_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register alone (no input-to-output paths).
    always_comb begin
        ser_en_s  = 1'b0;
        mux_sel_s = SEL_IDLE;
        busy_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mux_sel_s = SEL_IDLE;
            end
            ST_START: begin
                mux_sel_s = SEL_START;
                busy_s    = 1'b1;
            end
            ST_DATA: begin
                ser_en_s  = 1'b1;
                mux_sel_s = SEL_DATA;
                busy_s    = 1'b1;
            end
            ST_PARITY: begin
                mux_sel_s = SEL_PAR;
                busy_s    = 1'b1;
            end
            ST_STOP: begin
                mux_sel_s = SEL_IDLE;
                busy_s    = 1'b1;
            end
            default: begin
                mux_sel_s = SEL_IDLE;
            end
        endcase
    end

    assign ser_en  = ser_en_s;
    assign mux_sel = mux_sel_s;
    assign busy    = busy_s;

    uart_tx_mux u_mux (
        .CLK     (CLK),
        .RST     (RST),
        .mux_sel (mux_sel_s),
        .ser_out (ser_out),
        .par_bit (par_bit_r),
        .TX_OUT  (TX_OUT)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with an attached serializer model and a frame-level reference.
// Honors UART_TX_TWO_STOP_EN the same way as the design.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_done;
    logic       ser_out;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       busy;
    logic       TX_OUT;

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_out    (ser_out),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .TX_OUT     (TX_OUT)
    );

    // Serializer model: loads on accept, shifts LSB-first while enabled, clears its count otherwise.
    logic [7:0] sh_r;
    logic [2:0] cnt_r;
    logic       glitch = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= 3'd0;
        end else if (Data_Valid && !busy) begin
            sh_r  <= P_DATA;
            cnt_r <= 3'd0;
        end else if (ser_en) begin
            sh_r  <= {1'b0, sh_r[7:1]};
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= 3'd0;
        end
    end

    // Spurious done pulses outside DATA must be ignored by the sequencer.
    assign ser_done = (cnt_r == 3'd7) | (glitch & ~ser_en);
    assign ser_out  = sh_r[0];

    // Reference: per-cycle expectations for the frame in flight.
    int q_busy[$];
    int q_sen[$];
    int q_sel[$];
    int q_line[$];
    int cur_busy = 0, cur_sen = 0, cur_sel = 1, cur_line = 1;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push_cycle(input int b, input int s, input int m, input int l);
        q_busy.push_back(b);
        q_sen.push_back(s);
        q_sel.push_back(m);
        q_line.push_back(l);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        int ones;
        ones = 0;
        push_cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            push_cycle(1, 1, 2, int'(d[i]));
            ones += int'(d[i]);
        end
        if (pe) push_cycle(1, 0, 3, (ones % 2) ^ int'(pt));
        for (int i = 0; i < N_STOP; i++) push_cycle(1, 0, 1, 1);
    endtask

    task automatic tick();
        int exp_tx;
        if (RST) begin
            q_busy.delete(); q_sen.delete(); q_sel.delete(); q_line.delete();
            cur_busy = 0; cur_sen = 0; cur_sel = 1; cur_line = 1;
            exp_tx = 1;
        end else begin
            exp_tx = cur_line;
            if (cur_busy == 0 && Data_Valid) push_frame(P_DATA, PAR_EN, PAR_TYP);
            if (q_busy.size() > 0) begin
                cur_busy = q_busy.pop_front();
                cur_sen  = q_sen.pop_front();
                cur_sel  = q_sel.pop_front();
                cur_line = q_line.pop_front();
            end else begin
                cur_busy = 0; cur_sen = 0; cur_sel = 1; cur_line = 1;
            end
        end
        @(posedge CLK);
        #1;
        check_val("tx_out",  {7'd0, TX_OUT}, 8'(exp_tx));
        check_val("busy",    {7'd0, busy},   8'(cur_busy));
        check_val("ser_en",  {7'd0, ser_en}, 8'(cur_sen));
        check_val("mux_sel", {6'd0, mux_sel}, 8'(cur_sel));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset held, then quiet line.
        RST = 1'b1;
        run(3);
        RST = 1'b0;
        run(20);

        // Single frame, even parity, then odd parity, then no parity.
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run(16);
        PAR_TYP = 1'b1; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run(16);
        PAR_EN = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run(16);

        // Held valid: back-to-back frames with a byte change mid-frame.
        PAR_EN = 1'b1; PAR_TYP = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b1;
        tick();
        P_DATA = 8'hFF;
        run(26);
        Data_Valid = 1'b0;
        run(4);

        // Reset during DATA, then a clean frame.
        P_DATA = 8'h3C; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run(4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        run(3);
        P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run(16);

        // Randomized traffic with mid-frame input churn and spurious done pulses.
        for (int i = 0; i < 600; i++) begin
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            Data_Valid = ($urandom_range(0, 3) != 0);
            glitch     = ($urandom_range(0, 4) == 0);
            RST        = ($urandom_range(0, 149) == 0);
            tick();
        end
        RST = 1'b0; Data_Valid = 1'b0; glitch = 1'b0;
        run(16);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
